// File: rtl/wb_bot_pkg.sv
// Shared constants, register-select encoding and the address decoder for the
// Wishbone bot/sprite register bank.
package wb_bot_pkg;

  // Largest channel count the 8-bit address map can hold below the system block
  localparam int unsigned MAX_CH = 8;

  // Distance between consecutive channel register blocks
  localparam logic [7:0] CH_STRIDE = 8'h10;

  // Offsets inside a channel block
  localparam logic [7:0] OFS_INFO = 8'h00;
  localparam logic [7:0] OFS_CTRL = 8'h04;

  // System registers above the channel area
  localparam logic [7:0] ADR_STATUS  = 8'h80;
  localparam logic [7:0] ADR_INT_ACK = 8'h84;
  localparam logic [7:0] ADR_INT_EN  = 8'h88;
  localparam logic [7:0] ADR_ID      = 8'h8C;

  // Which register an access targets; REG_NONE means unmapped
  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_INFO    = 3'd1,
    REG_CTRL    = 3'd2,
    REG_STATUS  = 3'd3,
    REG_INT_ACK = 3'd4,
    REG_INT_EN  = 3'd5,
    REG_ID      = 3'd6
  } reg_sel_e;

  // Decoded access: target register and, for channel registers, the channel
  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] ch;
  } adr_dec_t;

  // Map the low address byte onto a register; misaligned, unknown offsets and
  // channels at or above num_ch all decode as unmapped.
  function automatic adr_dec_t decode_adr(input logic [7:0] adr,
                                          input logic [3:0] num_ch);
    adr_dec_t dec;
    dec.sel = REG_NONE;
    dec.ch  = adr[6:4];
    if (adr[1:0] != 2'b00) begin
      dec.sel = REG_NONE;
    end else if (adr[7] == 1'b0) begin
      if ({1'b0, adr[6:4]} >= num_ch) begin
        dec.sel = REG_NONE;
      end else if (adr[3:0] == OFS_INFO[3:0]) begin
        dec.sel = REG_INFO;
      end else if (adr[3:0] == OFS_CTRL[3:0]) begin
        dec.sel = REG_CTRL;
      end else begin
        dec.sel = REG_NONE;
      end
    end else begin
      case (adr)
        ADR_STATUS:  dec.sel = REG_STATUS;
        ADR_INT_ACK: dec.sel = REG_INT_ACK;
        ADR_INT_EN:  dec.sel = REG_INT_EN;
        ADR_ID:      dec.sel = REG_ID;
        default:     dec.sel = REG_NONE;
      endcase
    end
    return dec;
  endfunction

  // Registers that software may read but never write
  function automatic logic is_read_only(input reg_sel_e sel);
    logic ro;
    case (sel)
      REG_INFO:   ro = 1'b1;
      REG_STATUS: ro = 1'b1;
      REG_ID:     ro = 1'b1;
      default:    ro = 1'b0;
    endcase
    return ro;
  endfunction

endpackage

// File: rtl/wb_bot_channel.sv
// One bot/sprite channel: byte-lane writable control word, info snapshot
// captured on the update pulse, and a sticky pending flag where a new update
// beats a simultaneous acknowledge.
module wb_bot_channel
  import wb_bot_pkg::*;
#(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned INFO_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ctrl_we_i,
  input  logic [3:0]        wsel_i,
  input  logic [31:0]       wdat_i,
  input  logic [INFO_W-1:0] info_i,
  input  logic              upd_i,
  input  logic              ack_clr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [INFO_W-1:0] shadow_o,
  output logic              pending_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [INFO_W-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;

  // Lanes and data bits beyond CTRL_W are simply not stored
  logic unused_s;
  assign unused_s = ^{wsel_i, wdat_i};

  // Control word next state: each bit follows its byte lane select
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_we_i) begin
      for (int i = 0; i < int'(CTRL_W); i++) begin
        ctrl_d[i] = wsel_i[i >> 3] ? wdat_i[i] : ctrl_q[i];
      end
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Snapshot and pending next state; update has priority over acknowledge
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (upd_i) begin
      shadow_d  = info_i;
      pending_d = 1'b1;
    end else if (ack_clr_i) begin
      shadow_d  = shadow_q;
      pending_d = 1'b0;
    end else begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign shadow_o  = shadow_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/wb_bot_regbank.sv
// Wishbone classic slave register bank for NUM_CH bot/sprite channels:
// address decode, registered single-cycle ack/err, read mux, interrupt
// enable mask and aggregated interrupt.
module wb_bot_regbank
  import wb_bot_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned INFO_W = 32,
  parameter logic [15:0] ID_VAL = 16'hB07B
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rtry_o,
  output logic [NUM_CH*CTRL_W-1:0] ctrl_o,
  input  logic [NUM_CH*INFO_W-1:0] info_i,
  input  logic [NUM_CH-1:0]        upd_i,
  output logic [NUM_CH-1:0]        pending_o,
  output logic                     irq_o
);

  // Response and system registers
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       dat_q, dat_d;
  logic [NUM_CH-1:0] int_en_q, int_en_d;
  logic              irq_q, irq_d;

  // Decode and per-channel strobes
  logic              req_s;
  adr_dec_t          dec_s;
  logic              bad_s;
  logic              wr_s;
  logic              rd_s;
  logic [31:0]       rdata_s;
  logic [NUM_CH-1:0] ctrl_we_s;
  logic [NUM_CH-1:0] ack_clr_s;
  logic [NUM_CH-1:0] pending_s;
  logic [CTRL_W-1:0] ch_ctrl_s   [NUM_CH];
  logic [INFO_W-1:0] ch_shadow_s [NUM_CH];

  // Only the low address byte is decoded; burst tags are not examined
  logic unused_s;
  assign unused_s = ^{wb_adr_i[31:8], wb_cti_i, wb_bte_i};

  // Request qualification and decode; a new request is ignored while a
  // response is on the bus, so back-to-back cycles complete every other clock
  always_comb begin
    req_s = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    dec_s = decode_adr(wb_adr_i[7:0], 4'(NUM_CH));
    bad_s = (dec_s.sel == REG_NONE) | (wb_we_i & is_read_only(dec_s.sel));
    wr_s  = req_s & ~bad_s & wb_we_i;
    rd_s  = req_s & ~bad_s & ~wb_we_i;
  end

  // Write strobes towards the channels and the interrupt enable register;
  // INT_EN and INT_ACK only look at byte lane 0
  always_comb begin
    for (int n = 0; n < int'(NUM_CH); n++) begin
      ctrl_we_s[n] = wr_s & (dec_s.sel == REG_CTRL) & (dec_s.ch == 3'(n));
    end
    if (wr_s && (dec_s.sel == REG_INT_ACK) && wb_sel_i[0]) begin
      ack_clr_s = wb_dat_i[NUM_CH-1:0];
    end else begin
      ack_clr_s = '0;
    end
    if (wr_s && (dec_s.sel == REG_INT_EN) && wb_sel_i[0]) begin
      int_en_d = wb_dat_i[NUM_CH-1:0];
    end else begin
      int_en_d = int_en_q;
    end
  end

  // Read mux; channel registers are zero-extended to the bus width
  always_comb begin
    rdata_s = 32'd0;
    case (dec_s.sel)
      REG_INFO: begin
        for (int n = 0; n < int'(NUM_CH); n++) begin
          rdata_s[INFO_W-1:0] = rdata_s[INFO_W-1:0] |
                                ((dec_s.ch == 3'(n)) ? ch_shadow_s[n] : '0);
        end
      end
      REG_CTRL: begin
        for (int n = 0; n < int'(NUM_CH); n++) begin
          rdata_s[CTRL_W-1:0] = rdata_s[CTRL_W-1:0] |
                                ((dec_s.ch == 3'(n)) ? ch_ctrl_s[n] : '0);
        end
      end
      REG_STATUS:  rdata_s[NUM_CH-1:0] = pending_s;
      REG_INT_EN:  rdata_s[NUM_CH-1:0] = int_en_q;
      REG_ID:      rdata_s = {ID_VAL, 8'(NUM_CH), 8'(CTRL_W)};
      default:     rdata_s = 32'd0;
    endcase
  end

  // Response next state: ack for mapped accesses, err otherwise; data is
  // only driven for read acks and stays zero on errors
  always_comb begin
    ack_d = req_s & ~bad_s;
    err_d = req_s & bad_s;
    if (rd_s) begin
      dat_d = rdata_s;
    end else begin
      dat_d = 32'd0;
    end
    irq_d = |(pending_s & int_en_q);
  end

  // Bus response, interrupt enable and interrupt output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= 32'd0;
      int_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      int_en_q <= int_en_d;
      irq_q    <= irq_d;
    end
  end

  for (genvar n = 0; n < int'(NUM_CH); n++) begin : g_ch
    wb_bot_channel #(
      .CTRL_W (CTRL_W),
      .INFO_W (INFO_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .ctrl_we_i (ctrl_we_s[n]),
      .wsel_i    (wb_sel_i),
      .wdat_i    (wb_dat_i),
      .info_i    (info_i[n*INFO_W +: INFO_W]),
      .upd_i     (upd_i[n]),
      .ack_clr_i (ack_clr_s[n]),
      .ctrl_o    (ch_ctrl_s[n]),
      .shadow_o  (ch_shadow_s[n]),
      .pending_o (pending_s[n])
    );
    assign ctrl_o[n*CTRL_W +: CTRL_W] = ch_ctrl_s[n];
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_rtry_o = 1'b0;
  assign pending_o = pending_s;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_bot_regbank.sv
// Randomised self-checking bench for wb_bot_regbank (4 channels, 8-bit ctrl,
// 32-bit info) against a transaction-level reference model.
module tb_wb_bot_regbank;

  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  wb_adr_i;
  logic [31:0]  wb_dat_i;
  logic [3:0]   wb_sel_i;
  logic         wb_we_i;
  logic         wb_cyc_i;
  logic         wb_stb_i;
  logic [2:0]   wb_cti_i;
  logic [1:0]   wb_bte_i;
  logic [31:0]  wb_dat_o;
  logic         wb_ack_o;
  logic         wb_err_o;
  logic         wb_rtry_o;
  logic [31:0]  ctrl_o;
  logic [127:0] info_i;
  logic [3:0]   upd_i;
  logic [3:0]   pending_o;
  logic         irq_o;

  wb_bot_regbank #(
    .NUM_CH (4),
    .CTRL_W (8),
    .INFO_W (32),
    .ID_VAL (16'hB07B)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cti_i  (wb_cti_i),
    .wb_bte_i  (wb_bte_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_rtry_o (wb_rtry_o),
    .ctrl_o    (ctrl_o),
    .info_i    (info_i),
    .upd_i     (upd_i),
    .pending_o (pending_o),
    .irq_o     (irq_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]   m_ctrl   [NCH];
  logic [31:0]  m_shadow [NCH];
  logic [3:0]   m_pend;
  logic [3:0]   m_en;
  logic         m_irq;
  logic         m_ack;
  logic         m_err;
  logic         m_rd;
  logic [31:0]  m_dat;
  logic [127:0] info_cur;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ctrl[i]   = 8'h00;
      m_shadow[i] = 32'h0;
    end
    m_pend = 4'h0;
    m_en   = 4'h0;
    m_irq  = 1'b0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_rd   = 1'b0;
    m_dat  = 32'h0;
  endtask

  // One accepted bus access against the register map
  task automatic model_bus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic ok, output logic [31:0] rd,
                           output logic [3:0] clr);
    int a;
    a   = int'(adr[7:0]);
    ok  = 1'b1;
    rd  = 32'h0;
    clr = 4'h0;
    if (a % 4 != 0) ok = 1'b0;
    else if (a < 16 * NCH && a % 16 == 0) begin
      if (we) ok = 1'b0;
      else rd = m_shadow[a / 16];
    end else if (a < 16 * NCH && a % 16 == 4) begin
      if (we) begin
        if (sel[0]) m_ctrl[a / 16] = dat[7:0];
      end else rd = {24'h0, m_ctrl[a / 16]};
    end else if (a == 128) begin
      if (we) ok = 1'b0;
      else rd = {28'h0, m_pend};
    end else if (a == 132) begin
      if (we && sel[0]) clr = dat[3:0];
    end else if (a == 136) begin
      if (we) begin
        if (sel[0]) m_en = dat[3:0];
      end else rd = {28'h0, m_en};
    end else if (a == 140) begin
      if (we) ok = 1'b0;
      else rd = 32'hB07B0408;
    end else ok = 1'b0;
  endtask

  // Drive one clock's inputs, advance the model, compare after the edge
  task automatic step(input logic cyc, input logic stb, input logic [31:0] adr, input logic we,
                      input logic [31:0] dat, input logic [3:0] sel, input logic [3:0] upd,
                      input logic [127:0] info);
    logic        req;
    logic        ok;
    logic [31:0] rd;
    logic [3:0]  clr;
    logic        nxt_irq;
    wb_cyc_i = cyc;
    wb_stb_i = stb;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cti_i = 3'($urandom);
    wb_bte_i = 2'($urandom);
    upd_i    = upd;
    info_i   = info;
    nxt_irq  = |(m_pend & m_en);
    req      = cyc & stb & ~m_ack & ~m_err;
    ok  = 1'b0;
    rd  = 32'h0;
    clr = 4'h0;
    if (req) model_bus(adr, we, dat, sel, ok, rd, clr);
    m_ack = req & ok;
    m_err = req & ~ok;
    m_rd  = req & ok & ~we;
    m_dat = m_rd ? rd : 32'h0;
    m_pend = (m_pend & ~clr) | upd;
    for (int i = 0; i < NCH; i++) begin
      if (upd[i]) m_shadow[i] = info[i*32 +: 32];
    end
    m_irq = nxt_irq;
    @(posedge clk);
    @(negedge clk);
    check_eq("ack", {63'h0, wb_ack_o}, {63'h0, m_ack});
    check_eq("err", {63'h0, wb_err_o}, {63'h0, m_err});
    if (m_rd || m_err) check_eq("rdata", {32'h0, wb_dat_o}, {32'h0, m_dat});
    check_eq("ctrl", {32'h0, ctrl_o}, {32'h0, m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
    check_eq("pending", {60'h0, pending_o}, {60'h0, m_pend});
    check_eq("irq", {63'h0, irq_o}, {63'h0, m_irq});
    check_eq("rtry", {63'h0, wb_rtry_o}, 64'h0);
  endtask

  task automatic idle(input logic [3:0] upd);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, upd, info_cur);
  endtask

  task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    step(1'b1, 1'b1, adr, we, dat, sel, 4'h0, info_cur);
    idle(4'h0);
  endtask

  function automatic logic [7:0] pick_adr();
    logic [7:0] tbl [16];
    tbl = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h20, 8'h24, 8'h30, 8'h34,
            8'h40, 8'h44, 8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h16};
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    return tbl[$urandom_range(0, 15)];
  endfunction

  initial begin
    rstn     = 1'b0;
    wb_adr_i = 32'h0;
    wb_dat_i = 32'h0;
    wb_sel_i = 4'h0;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_cti_i = 3'h0;
    wb_bte_i = 2'h0;
    upd_i    = 4'h0;
    info_cur = 128'h0;
    info_i   = info_cur;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_ack", {63'h0, wb_ack_o}, 64'h0);
    check_eq("rst_err", {63'h0, wb_err_o}, 64'h0);
    check_eq("rst_dat", {32'h0, wb_dat_o}, 64'h0);
    check_eq("rst_ctrl", {32'h0, ctrl_o}, 64'h0);
    check_eq("rst_pending", {60'h0, pending_o}, 64'h0);
    check_eq("rst_irq", {63'h0, irq_o}, 64'h0);
    rstn = 1'b1;
    idle(4'h0);

    // ID and STATUS after reset
    step(1'b1, 1'b1, 32'h0000_008C, 1'b0, 32'h0, 4'hF, 4'h0, info_cur);
    check_eq("id_value", {32'h0, wb_dat_o}, 64'hB07B0408);
    idle(4'h0);
    bus(32'h80, 1'b0, 32'h0, 4'hF);

    // Byte-lane CTRL writes
    bus(32'h14, 1'b1, 32'h0000_00A5, 4'b0001);
    check_eq("ctrl1_a5", {56'h0, ctrl_o[15:8]}, 64'hA5);
    bus(32'h14, 1'b0, 32'h0, 4'hF);
    bus(32'h14, 1'b1, 32'h0000_005A, 4'b0000);
    check_eq("ctrl1_nosel", {56'h0, ctrl_o[15:8]}, 64'hA5);
    bus(32'h34, 1'b1, 32'h1234_56C3, 4'b1110);
    bus(32'h34, 1'b1, 32'h1234_56C3, 4'b0001);

    // Snapshot is coherent with the update pulse, not the live value
    info_cur[95:64] = 32'h1122_3344;
    idle(4'b0100);
    info_cur[95:64] = 32'hFFFF_FFFF;
    idle(4'h0);
    step(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 4'hF, 4'h0, info_cur);
    check_eq("shadow2", {32'h0, wb_dat_o}, 64'h1122_3344);
    idle(4'h0);
    bus(32'h80, 1'b0, 32'h0, 4'hF);

    // Interrupt enable, irq, W1C acknowledge
    bus(32'h88, 1'b1, 32'h4, 4'b0001);
    idle(4'h0);
    check_eq("irq_on", {63'h0, irq_o}, 64'h1);
    step(1'b1, 1'b1, 32'h84, 1'b1, 32'h4, 4'b0001, 4'h0, info_cur);
    check_eq("ack_clr2", {63'h0, pending_o[2]}, 64'h0);
    idle(4'h0);
    check_eq("irq_off", {63'h0, irq_o}, 64'h0);

    // Update and acknowledge in the same cycle: set wins
    idle(4'b0010);
    step(1'b1, 1'b1, 32'h84, 1'b1, 32'h2, 4'b0001, 4'b0010, info_cur);
    check_eq("set_wins", {63'h0, pending_o[1]}, 64'h1);
    idle(4'h0);

    // Error responses with no state change
    bus(32'h40, 1'b0, 32'h0, 4'hF);
    bus(32'h00, 1'b1, 32'hDEAD_BEEF, 4'hF);
    bus(32'h90, 1'b0, 32'h0, 4'hF);
    bus(32'h16, 1'b0, 32'h0, 4'hF);
    bus(32'h8C, 1'b1, 32'h0, 4'hF);
    bus(32'h80, 1'b1, 32'hF, 4'hF);

    // Randomised traffic, including strobes held through the response cycle
    for (int it = 0; it < 600; it++) begin
      logic       cyc;
      logic [3:0] upd;
      info_cur = {$urandom, $urandom, $urandom, $urandom};
      cyc = ($urandom_range(0, 9) < 7);
      upd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(cyc, cyc & ($urandom_range(0, 7) != 0), {24'($urandom), pick_adr()},
           1'($urandom), $urandom, 4'($urandom), upd, info_cur);
    end

    // Reset while a request is outstanding
    bus(32'h04, 1'b1, 32'hFF, 4'h1);
    bus(32'h88, 1'b1, 32'hF, 4'h1);
    idle(4'b1001);
    idle(4'h0);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 32'h8C;
    wb_we_i  = 1'b0;
    #2 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_ack", {63'h0, wb_ack_o}, 64'h0);
    check_eq("mid_err", {63'h0, wb_err_o}, 64'h0);
    check_eq("mid_dat", {32'h0, wb_dat_o}, 64'h0);
    check_eq("mid_ctrl", {32'h0, ctrl_o}, 64'h0);
    check_eq("mid_pending", {60'h0, pending_o}, 64'h0);
    check_eq("mid_irq", {63'h0, irq_o}, 64'h0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle(4'h0);
    bus(32'h04, 1'b0, 32'h0, 4'hF);
    bus(32'h88, 1'b0, 32'h0, 4'hF);
    bus(32'h8C, 1'b0, 32'h0, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bot_regbank.md
Name: wb_bot_regbank

Overview:
- Parametrised Wishbone slave register bank serving NUM_CH bot/sprite channels from one 100 MHz domain.
- Per channel it provides:
  - a software-written control register driven to hardware;
  - a coherent info snapshot captured on the hardware update pulse;
  - a sticky update-pending flag.
- Adds over the single-bot controller: interrupt enable mask, aggregated IRQ, W1C acknowledge, byte-select writes, and bus error on unmapped or read-only accesses.

Parameters:
- NUM_CH, 4, number of channels, legal 1..8.
- CTRL_W, 8, control register width per channel, legal 1..32.
- INFO_W, 32, info word width per channel, legal 1..32.
- ID_VAL, 16'hB07B, constant returned in ID[31:16].

Ports:
- clk  in  1  system clock (100 MHz)
- rstn  in  1  reset, asynchronous, active-low
- wb_adr_i  in  32  byte address; only [7:0] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  ignored (classic cycles only)
- wb_bte_i  in  2  ignored
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  transfer error
- wb_rtry_o  out  1  tied 0
- ctrl_o  out  NUM_CH*CTRL_W  control words, channel n at [n*CTRL_W +: CTRL_W]
- info_i  in  NUM_CH*INFO_W  live info words, same packing
- upd_i  in  NUM_CH  one-cycle update pulses, synchronous to clk
- pending_o  out  NUM_CH  sticky pending flags
- irq_o  out  1  interrupt request

Behaviour:
- Address map:
  - Channel n base = n*0x10.
  - +0x0 INFO: RO, zero-extended snapshot.
  - +0x4 CTRL: RW, zero-extended.
  - 0x80 STATUS: RO, pending[NUM_CH-1:0].
  - 0x84 INT_ACK: W1C on pending; reads 0.
  - 0x88 INT_EN: RW, mask bits.
  - 0x8C ID: RO, {ID_VAL, 8'(NUM_CH), 8'(CTRL_W)}.
- Decode:
  - Access hits when adr[1:0]==0 and the address is listed above with channel n < NUM_CH.
  - Anything else is unmapped.
- Request: req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
- Response:
  - Registered, exactly 1 cycle after req.
  - Single-cycle pulse.
  - Mapped access → wb_ack_o.
  - Unmapped access, or write to INFO/STATUS/ID → wb_err_o, with no state change.
  - Back-to-back requests therefore complete every 2nd cycle.
- Read data: registered on the req cycle so it is valid with ack. On err, wb_dat_o = 0.
- CTRL write: byte lanes honoured; lane b updates bits [8b+7:8b] that exist within CTRL_W.
- INT_EN / INT_ACK writes: use lane 0 only. If wb_sel_i[0]=0, ack is still given with no effect.
- Info snapshot: on upd_i[n]=1, shadow[n] <= info_i[n] and pending[n] <= 1. Reads return the shadow, never the live value.
- Simultaneous upd_i[n] and INT_ACK clearing bit n in the same cycle: set wins, pending stays 1.
- irq_o: registered, irq_o <= |(pending & int_en). Deasserts the cycle after the last enabled pending bit clears.
- Reset (rstn low, async), all cleared:
  - wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0.
  - ctrl = 0, shadow = 0, pending = 0, int_en = 0, irq_o = 0.
- Reset mid-transfer: the in-flight cycle gets no ack and no err; the master must retry.
- wb_cti_i and wb_bte_i are not examined; bursts degrade to classic.

Decomposition:
- Package wb_bot_pkg holds:
  - offset constants: OFS_INFO, OFS_CTRL, ADR_STATUS, ADR_INT_ACK, ADR_INT_EN, ADR_ID;
  - CH_STRIDE = 0x10;
  - MAX_CH = 8.
- Sub-module wb_bot_channel, generated NUM_CH times, holds:
  - the ctrl register with byte-lane write;
  - the info shadow;
  - the pending FF with set-priority.
- The top level holds address decode, ack/err generation, the read mux, INT_EN and irq.

Test Plan:
- Reset, then read 0x8C → ack, data 0xB07B0408. Read 0x80 → 0. irq_o=0.
- Write 0x0000_00A5 to 0x14 with sel=4'b0001 → ctrl_o[15:8]=0xA5. Read 0x14 → 0x000000A5. Write sel=4'b0000 → ctrl unchanged, ack.
- info_i ch2=0x11223344, pulse upd_i[2], then change info_i to 0xFFFFFFFF → read 0x20 returns 0x11223344. STATUS=0x4.
- INT_EN=0x4 with pending[2]=1 → irq_o=1. Write INT_ACK 0x4 → pending_o[2]=0 and irq_o=0 one cycle later.
- upd_i[1] pulse in the same cycle INT_ACK writes 0x2 → pending_o[1] stays 1.
- Read 0x40 (ch4, NUM_CH=4), write to 0x00, read 0x90 → wb_err_o pulse, no ack, no state change. Assert rstn low during an outstanding req → no ack, all outputs zero.
